// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the BIP fetch stage: default widths, opcodes and fetch FSM states.
package instr_fetch_pkg;

    localparam int unsigned ADDR_BUS    = 11;
    localparam int unsigned DATA_SIZE   = 16;
    localparam int unsigned OPCODE_BITS = 5;
    localparam int unsigned COUNT_W     = 16;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_HLT  = 5'd0,
        OP_STO  = 5'd1,
        OP_LD   = 5'd2,
        OP_LDI  = 5'd3,
        OP_ADD  = 5'd4,
        OP_ADDI = 5'd5,
        OP_SUB  = 5'd6,
        OP_SUBI = 5'd7
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment, otherwise holds; wraps modulo 2^W.
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter int unsigned W = ADDR_BUS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// BIP fetch stage: drives Prog_Mem address from the PC, registers the returned word and
// hands it to execute over valid/ready, with branch redirect, HLT stop and retire count.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned addr_bus    = ADDR_BUS,
    parameter int unsigned data_size   = DATA_SIZE,
    parameter int unsigned opcode_bits = OPCODE_BITS
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic [addr_bus-1:0]    Addr,
    input  logic [data_size-1:0]   Data,
    output logic                   Instr_Valid,
    input  logic                   Instr_Ready,
    output logic [opcode_bits-1:0] Opcode,
    output logic [addr_bus-1:0]    Operand,
    output logic [addr_bus-1:0]    Pc_Out,
    input  logic                   Branch_En,
    input  logic [addr_bus-1:0]    Branch_Target,
    output logic                   Halted,
    output logic [COUNT_W-1:0]     Instr_Count
);

    state_e                 state_q;
    state_e                 state_d;
    logic [data_size-1:0]   ir_q;
    logic [addr_bus-1:0]    pc_out_q;
    logic [addr_bus-1:0]    pc;
    logic                   valid_q;
    logic                   valid_d;
    logic                   halted_q;
    logic                   halted_d;
    logic [COUNT_W-1:0]     count_q;
    logic                   accept;
    logic                   is_hlt;
    logic                   pc_inc;
    logic                   pc_load;
    logic                   ir_load;
    logic                   count_en;

    pc_reg #(
        .W (addr_bus)
    ) u_pc_reg (
        .clk      (Clk),
        .rst_n    (Reset),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (Branch_Target),
        .pc       (pc)
    );

    assign accept = valid_q & Instr_Ready;
    assign is_hlt = (ir_q[data_size-1 -: opcode_bits] == opcode_bits'(OP_HLT));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls; a branch squashes whatever is held, even if accepted.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ir_load  = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Branch_En) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    count_en = accept;
                    if (accept && is_hlt) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else if (!valid_q || accept) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Instruction register and the address it came from.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir_q     <= '0;
            pc_out_q <= '0;
        end else if (ir_load) begin
            ir_q     <= Data;
            pc_out_q <= pc;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= sat_inc(count_q);
        end
    end

    assign Addr        = pc;
    assign Instr_Valid = valid_q;
    assign Opcode      = ir_q[data_size-1 -: opcode_bits];
    assign Operand     = ir_q[addr_bus-1:0];
    assign Pc_Out      = pc_out_q;
    assign Halted      = halted_q;
    assign Instr_Count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a
// program-order reference model feeding a scoreboard of expected presented instructions.
module tb_instr_fetch;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 16;
    localparam int unsigned OW    = 5;
    localparam int unsigned DEPTH = 2048;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Data;
    logic          Instr_Valid;
    logic          Instr_Ready = 1'b0;
    logic [OW-1:0] Opcode;
    logic [AW-1:0] Operand;
    logic [AW-1:0] Pc_Out;
    logic          Branch_En = 1'b0;
    logic [AW-1:0] Branch_Target = '0;
    logic          Halted;
    logic [15:0]   Instr_Count;

    logic [DW-1:0] mem [0:DEPTH-1];
    assign Data = mem[Addr];

    instr_fetch dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Addr          (Addr),
        .Data          (Data),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Opcode        (Opcode),
        .Operand       (Operand),
        .Pc_Out        (Pc_Out),
        .Branch_En     (Branch_En),
        .Branch_Target (Branch_Target),
        .Halted        (Halted),
        .Instr_Count   (Instr_Count)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Program-order reference: which address is fetched next, what is being presented, retire count.
    typedef struct {
        int            pc;
        logic [DW-1:0] word;
    } exp_t;

    exp_t          q[$];
    int            m_fetch  = 0;
    bit            m_valid  = 1'b0;
    bit            m_halted = 1'b0;
    int            m_cnt    = 0;
    logic [DW-1:0] m_word   = '0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_fetch  = 0;
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_cnt    = 0;
            m_word   = '0;
            q.delete();
        end else if (!m_halted) begin
            if (Branch_En) begin
                m_fetch = int'(Branch_Target);
                m_valid = 1'b0;
            end else begin
                bit took;
                took = m_valid && Instr_Ready;
                if (took && m_cnt < 65535) m_cnt = m_cnt + 1;
                if (took && m_word[DW-1 -: OW] == 5'd0) begin
                    m_halted = 1'b1;
                    m_valid  = 1'b0;
                end else if (!m_valid || took) begin
                    exp_t e;
                    e.pc    = m_fetch;
                    e.word  = mem[m_fetch];
                    m_word  = e.word;
                    m_valid = 1'b1;
                    q.push_back(e);
                    m_fetch = (m_fetch + 1) % DEPTH;
                end
            end
        end
    end

    // Monitor: pop an expectation for each newly presented instruction; held values must not move.
    bit   seen_valid = 1'b0;
    bit   seen_acc   = 1'b0;
    exp_t held;

    always @(negedge Clk) begin
        chk("valid",  32'(Instr_Valid), 32'(m_valid));
        chk("count",  32'(Instr_Count), 32'(m_cnt));
        chk("halted", 32'(Halted),      32'(m_halted));
        chk("addr",   32'(Addr),        32'(m_fetch));
        if (Instr_Valid) begin
            if (!seen_valid || seen_acc) begin
                chk("sb_pending", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) held = q.pop_front();
            end
            chk("pc_out",  32'(Pc_Out),  32'(held.pc));
            chk("opcode",  32'(Opcode),  32'(held.word[DW-1 -: OW]));
            chk("operand", 32'(Operand), 32'(held.word[AW-1:0]));
        end
        seen_valid = Instr_Valid;
        seen_acc   = Instr_Valid & Instr_Ready;
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic load_prog();
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {5'd4, 11'(i)};
        mem[0] = 16'h1801;
        mem[1] = 16'h2002;
        mem[2] = 16'h2803;
        mem[3] = 16'h0000;
    endtask

    task automatic fill_random();
        logic [OW-1:0] op;
        for (int i = 0; i < int'(DEPTH); i++) begin
            op = OW'($urandom_range(1, 7));
            if ($urandom_range(0, 63) == 0) op = '0;
            mem[i] = {op, AW'($urandom)};
        end
    endtask

    // Reset for one edge, released two units after the following edge.
    task automatic reset_pulse();
        Instr_Ready = 1'b0;
        Branch_En   = 1'b0;
        Reset       = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    initial begin
        load_prog();
        #1 Reset = 1'b0;
        repeat (2) step();
        chk("rst_valid",   32'(Instr_Valid), 32'd0);
        chk("rst_count",   32'(Instr_Count), 32'd0);
        chk("rst_halted",  32'(Halted),      32'd0);
        chk("rst_addr",    32'(Addr),        32'd0);
        chk("rst_opcode",  32'(Opcode),      32'd0);
        chk("rst_operand", 32'(Operand),     32'd0);
        chk("rst_pc_out",  32'(Pc_Out),      32'd0);

        // Sequential run to HLT at address 3
        Reset = 1'b1;
        Instr_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Halted) break;
        end
        chk("halt_reached", 32'(Halted),      32'd1);
        chk("halt_valid",   32'(Instr_Valid), 32'd0);
        chk("halt_count",   32'(Instr_Count), 32'd4);

        // HALT ignores branch and ready
        Branch_En = 1'b1;
        Branch_Target = 11'd100;
        repeat (5) begin
            step();
            chk("imm_count",  32'(Instr_Count), 32'd4);
            chk("imm_halted", 32'(Halted),      32'd1);
            chk("imm_addr",   32'(Addr),        32'd4);
            chk("imm_valid",  32'(Instr_Valid), 32'd0);
        end

        // Stall while mem[1] is held
        reset_pulse();
        Instr_Ready = 1'b1;
        step();
        step();
        Instr_Ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_pc_out", 32'(Pc_Out),      32'd1);
            chk("stall_opcode", 32'(Opcode),      32'd4);
            chk("stall_addr",   32'(Addr),        32'd2);
            chk("stall_count",  32'(Instr_Count), 32'd1);
        end
        Instr_Ready = 1'b1;
        step();
        chk("unstall_pc_out", 32'(Pc_Out), 32'd2);
        chk("unstall_opcode", 32'(Opcode), 32'd5);

        // Branch squashes mem[1]
        reset_pulse();
        Instr_Ready = 1'b1;
        step();
        step();
        Branch_En = 1'b1;
        Branch_Target = 11'd100;
        step();
        Branch_En = 1'b0;
        chk("br_bubble", 32'(Instr_Valid), 32'd0);
        chk("br_count",  32'(Instr_Count), 32'd1);
        chk("br_addr",   32'(Addr),        32'd100);
        step();
        chk("br_valid",  32'(Instr_Valid), 32'd1);
        chk("br_target", 32'(Pc_Out),      32'd100);
        step();
        chk("br_next",   32'(Pc_Out),      32'd101);
        chk("br_count2", 32'(Instr_Count), 32'd2);

        // Wrap from 2047 to 0
        Branch_En = 1'b1;
        Branch_Target = 11'd2047;
        step();
        Branch_En = 1'b0;
        step();
        chk("wrap_top", 32'(Pc_Out), 32'd2047);
        step();
        chk("wrap_zero", 32'(Pc_Out), 32'd0);

        // Asynchronous reset between edges while valid
        #1 Reset = 1'b0;
        #1;
        chk("async_valid",  32'(Instr_Valid), 32'd0);
        chk("async_count",  32'(Instr_Count), 32'd0);
        chk("async_halted", 32'(Halted),      32'd0);
        step();
        Reset = 1'b1;
        step();
        chk("restart_valid",  32'(Instr_Valid), 32'd1);
        chk("restart_pc_out", 32'(Pc_Out),      32'd0);

        // Randomized traffic
        fill_random();
        reset_pulse();
        for (int c = 0; c < 4000; c++) begin
            Instr_Ready   = ($urandom_range(0, 9) < 7);
            Branch_En     = ($urandom_range(0, 11) == 0);
            Branch_Target = AW'($urandom);
            if (m_halted && $urandom_range(0, 3) == 0) begin
                reset_pulse();
            end else if ($urandom_range(0, 299) == 0) begin
                #1 Reset = 1'b0;
                step();
                Reset = 1'b1;
            end else begin
                step();
            end
        end
        Instr_Ready = 1'b0;
        Branch_En   = 1'b0;
        @(negedge Clk);
        #1;
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the BIP datapath, sitting directly upstream of `Prog_Mem`. It owns the program counter and drives `Prog_Mem`'s `Addr`, then registers the returned 16-bit word into an instruction register. It presents the decoded opcode/operand to the execute stage over a valid/ready handshake. It also handles branch redirects from execute, stops fetching on `HLT`, and counts retired instructions for bench visibility.

## Interface
- `addr_bus`, 11: program address width; also the operand width.
- `data_size`, 16: instruction word width.
- `opcode_bits`, 5: opcode field width; `opcode_bits + addr_bus` must equal `data_size`.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Addr` out addr_bus: program memory address, equal to PC (combinational from the PC register).
- `Data` in data_size: program memory read word; combinational response to `Addr`.
- `Instr_Valid` out 1: opcode/operand/`Pc_Out` hold a live instruction.
- `Instr_Ready` in 1: execute accepts the instruction this cycle.
- `Opcode` out opcode_bits: IR[data_size-1 -: opcode_bits].
- `Operand` out addr_bus: IR[addr_bus-1:0].
- `Pc_Out` out addr_bus: address the current IR was fetched from.
- `Branch_En` in 1: redirect request from execute.
- `Branch_Target` in addr_bus: redirect address.
- `Halted` out 1: an `HLT` instruction has been accepted.
- `Instr_Count` out 16: number of accepted instructions, saturating at 16'hFFFF.

## Operation
- States: RUN and HALT; the state register is cleared to RUN by reset.
- Reset values: PC=0, IR=0 (so `Opcode`=0 and `Operand`=0), `Pc_Out`=0, `Instr_Valid`=0, `Halted`=0, `Instr_Count`=0.
- Handshake (`accept` = `Instr_Valid & Instr_Ready`):
  - An instruction is accepted only on a cycle where both signals are high.
  - While `Instr_Valid=1` and `Instr_Ready=0`, `Opcode`, `Operand` and `Pc_Out` are held stable.
- RUN, load condition `(!Instr_Valid | accept)`, with `Branch_En=0` and the accepted opcode not `HLT`:
  - IR <= `Data`, `Pc_Out` <= PC, PC <= PC+1, `Instr_Valid` <= 1.
- PC increments modulo 2^addr_bus: 2047 wraps to 0 with no flag.
- `HLT` = opcode 5'b00000. On `accept` of an `HLT`:
  - `Instr_Valid` <= 0, `Halted` <= 1, state <= HALT.
  - No further load; PC is unchanged.
- HALT is absorbing until `Reset`:
  - `Branch_En` and `Instr_Ready` are ignored.
  - `Addr` stays at the last PC.
- Branch (RUN, `Branch_En=1`) has priority over load:
  - PC <= `Branch_Target`, `Instr_Valid` <= 0.
  - The held instruction is squashed, even if `Instr_Ready=1` in the same cycle: it is not counted and `Halted` is not set, even for an `HLT`.
- `Instr_Count` increments on every `accept`, including the `HLT` itself, and is never incremented on a squash.
- Reset asserted mid-operation: all state returns asynchronously to the reset values; fetch restarts at address 0 on the first edge after release.

## Timing
- Fetch latency:
  - `Addr` = PC in the same cycle.
  - `Data` is sampled at the next rising edge.
  - `Instr_Valid` rises in the cycle after that edge.
  - Reset release → first valid instruction (mem[0]) after 1 edge.
- Throughput: one instruction per cycle when `Instr_Ready` is held at 1.
- Branch latency:
  - Edge 1: PC ← target, valid cleared.
  - Edge 2: mem[target] loaded and valid.
  - Exactly one bubble cycle.
- `Halted` rises on the edge that accepts `HLT`; `Instr_Valid` falls on that same edge.
- `Branch_En` asserted together with a stall (`Instr_Ready=0`) is still taken immediately.

## Structure
- Shared package holds:
  - Opcode constants: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7.
  - The default widths `addr_bus=11`, `data_size=16`, `opcode_bits=5`.
  - The RUN/HALT state encoding.
- One natural sub-module, `pc_reg`: the PC register with increment/load/hold and async active-low clear, reused by later BIP variants.
- IR, handshake and counter logic stay in `instr_fetch`.

## Test plan
- Reset then sequential run: `Prog_Mem` holds mem[0..3] = 16'h1801, 16'h2002, 16'h2803, 16'h0000, with `Instr_Ready`=1.
  - Required: `Pc_Out` 0,1,2,3 on consecutive cycles; `Opcode` 3,4,5,0 with `Operand` 1,2,3,0.
  - After `HLT` is accepted: `Halted`=1, `Instr_Valid`=0, `Instr_Count`=4.
- Stall: hold `Instr_Ready`=0 for 3 cycles while IR holds mem[1].
  - Required: outputs stable and PC=2 throughout; after release, mem[2] follows on the next cycle.
- Branch: assert `Branch_En`=1 with `Branch_Target`=11'd100 while mem[1] is valid with `Instr_Ready`=1.
  - Required: mem[1] is not counted; one bubble cycle; then `Pc_Out`=100.
- Wrap: branch to 2047 with `Instr_Ready`=1.
  - Required: `Pc_Out` shows 2047 then 0.
- Mid-run reset: pull `Reset` low asynchronously between edges while `Instr_Valid`=1.
  - Required: `Instr_Valid`, `Instr_Count` and `Halted` clear immediately; after release, `Pc_Out`=0 on the first valid.
- HALT immunity: after `Halted`=1, apply `Branch_En`=1 and `Instr_Ready`=1 for 5 cycles.
  - Required: no state change and `Instr_Count` unchanged.
